ctrlwei_sched: RTL and testbench
================================

Name: ctrlwei_sched

Overview:
- Parametrised weight-dispatch controller. Hands weight-ready tokens to NUM_PEC PE clusters one at a time, MSB to LSB.
- Adds three things a fixed sweep controller does not have:
  - a run-time PEC enable mask, with disabled PECs skipped;
  - a programmable sweep (round) count with a Done pulse;
  - a sweep/position status readout.
- Sits between the weight distributor FIFO (DISWEI) and the PEC array. Each fetch pulse advances the weight pipeline by one beat.

Parameters:
- NUM_PEC, 48, number of PE clusters served.
- ROUND_W, 8, width of the sweep-count configuration and counter.
- TMO_W, 10, width of the stall watchdog counter (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse; launches a job (honoured only in IDLE).
- Reset  in  1  synchronous soft abort; highest priority after rst_n.
- CfgMask  in  NUM_PEC  enabled PECs; sampled on Start.
- CfgRounds  in  ROUND_W  number of full sweeps minus 1; sampled on Start.
- DISWEI_RdyFIFO  in  1  distributor has a weight word available.
- CTRLWEI_PlsFetch  out  1  combinational one-cycle fetch pulse to DISWEI.
- PECCTRLWEI_GetWei  in  NUM_PEC  per-PEC weight-consumed strobe.
- CTRLWEIPEC_RdyWei  out  NUM_PEC  registered one-hot weight-ready token.
- CTRLWEI_Done  out  1  registered one-cycle pulse at job completion.
- CTRLWEI_Busy  out  1  high in any state other than IDLE.
- CTRLWEI_IdPec  out  clog2(NUM_PEC)  current PEC index.
- CTRLWEI_Round  out  ROUND_W  current sweep number.
- CTRLWEI_Err  out  1  sticky stall-timeout error (optional feature only; otherwise tied 0).

Behaviour:
- Reset values (rst_n low):
  - state=IDLE; RdyWei=0; Done=0; Err=0; Round=0.
  - IdPec=NUM_PEC-1; mask and rounds registers = 0.
- States: IDLE, WAIT_FIFO, WAIT_GET, DONE.
- IDLE:
  - On Start: latch CfgMask and CfgRounds; Round=0; IdPec = highest set bit of CfgMask; go to WAIT_FIFO.
  - If CfgMask==0: go to DONE instead.
  - Start while not in IDLE is ignored.
- WAIT_FIFO:
  - When DISWEI_RdyFIFO=1: PlsFetch=1 in that same cycle; next state WAIT_GET; RdyWei[IdPec] set on the next edge.
  - Latency from fetch pulse to token visible is 1 clk.
  - PlsFetch is 0 in every other state/condition.
- WAIT_GET:
  - RdyWei holds one-hot at IdPec until GetWei[IdPec]=1.
  - GetWei bits of other PECs are ignored; they do not advance and do not clear the token.
  - On an accepted GetWei:
    - RdyWei cleared at the next edge.
    - IdPec advances to the next lower set mask bit.
    - If no lower bit is set: IdPec wraps to the highest set bit and Round increments.
    - If Round==latched rounds and the wrap would occur: go to DONE. Otherwise go to WAIT_FIFO.
- DONE: Done=1 for exactly one cycle; then IDLE. IdPec and Round hold their final values until the next Start.
- Next-index search: combinational priority encoder over the latched mask, descending; no extra cycle.
- Reset (soft), in any state:
  - Next edge: state=IDLE, RdyWei=0, IdPec=NUM_PEC-1, Round=0.
  - No PlsFetch and no Done in that cycle, even if RdyFIFO or GetWei are high.
- Simultaneous Reset and Start: Reset wins; the block stays IDLE.
- A single-bit mask gives one fetch per sweep to the same PEC.
- At most one token is outstanding at any time; RdyWei is never more than one-hot.

Optional Feature:
- Macro: CTRLWEI_STALL_TMO_EN.
- With the macro defined:
  - A TMO_W-bit counter clears on entry to WAIT_GET and increments each cycle in WAIT_GET.
  - On reaching all-ones: Err is set (sticky), RdyWei is cleared, state goes to IDLE, Done is not pulsed.
  - Err clears only on rst_n or soft Reset.
- Without the macro: no counter; Err is tied 0; WAIT_GET waits indefinitely.

Test Plan:
- NUM_PEC=4, CfgMask=4'b1111, CfgRounds=0, RdyFIFO tied 1, each GetWei returned 2 clk after the token → PlsFetch pulses 4 times; RdyWei sequence 1000, 0100, 0010, 0001; Done one cycle after the last GetWei; Busy then drops.
- CfgMask=4'b1010, CfgRounds=2 → RdyWei order 1000, 0010 repeated 3 times; Round steps 0, 1, 2; exactly one Done; 6 PlsFetch total.
- RdyFIFO held low 5 clk in WAIT_FIFO → no PlsFetch and RdyWei=0 during that time; PlsFetch occurs in the same cycle RdyFIFO rises; token appears 1 clk later.
- During token at PEC 2, pulse GetWei=4'b0001 (wrong PEC) → no state change; then GetWei=4'b0100 → advances to PEC 1.
- Soft Reset asserted while in WAIT_GET at Round=1 → next cycle: IDLE, RdyWei=0, IdPec=3, Round=0, no Done; a subsequent Start reruns cleanly. CfgMask=0 with Start → Done pulses 2 clk after Start, no PlsFetch.
- With CTRLWEI_STALL_TMO_EN, TMO_W=4, GetWei withheld → Err rises 15 clk after token assertion, RdyWei clears, no Done; Err persists until soft Reset.

Source files
------------

// File: rtl/ctrlwei_sched_if.sv
// Scheduler-side bundle: config/start, the DISWEI fetch handshake, per-PEC token handshake, status.
// Modport master is the scheduler; slave is whatever drives the inputs and observes the outputs.
interface ctrlwei_sched_if #(
    parameter int unsigned NUM_PEC = 48,
    parameter int unsigned ROUND_W = 8
);
    localparam int unsigned IdW = (NUM_PEC > 1) ? $clog2(NUM_PEC) : 1;

    logic               Start;
    logic               Reset;
    logic [NUM_PEC-1:0] CfgMask;
    logic [ROUND_W-1:0] CfgRounds;
    logic               DISWEI_RdyFIFO;
    logic               CTRLWEI_PlsFetch;
    logic [NUM_PEC-1:0] PECCTRLWEI_GetWei;
    logic [NUM_PEC-1:0] CTRLWEIPEC_RdyWei;
    logic               CTRLWEI_Done;
    logic               CTRLWEI_Busy;
    logic [IdW-1:0]     CTRLWEI_IdPec;
    logic [ROUND_W-1:0] CTRLWEI_Round;
    logic               CTRLWEI_Err;

    modport master (
        input  Start, Reset, CfgMask, CfgRounds, DISWEI_RdyFIFO, PECCTRLWEI_GetWei,
        output CTRLWEI_PlsFetch, CTRLWEIPEC_RdyWei, CTRLWEI_Done, CTRLWEI_Busy,
               CTRLWEI_IdPec, CTRLWEI_Round, CTRLWEI_Err
    );

    modport slave (
        output Start, Reset, CfgMask, CfgRounds, DISWEI_RdyFIFO, PECCTRLWEI_GetWei,
        input  CTRLWEI_PlsFetch, CTRLWEIPEC_RdyWei, CTRLWEI_Done, CTRLWEI_Busy,
               CTRLWEI_IdPec, CTRLWEI_Round, CTRLWEI_Err
    );
endinterface

// File: rtl/ctrlwei_sched.sv
// Weight-dispatch controller: hands one weight token at a time to enabled PECs, MSB to LSB,
// for a programmable number of sweeps. Define CTRLWEI_STALL_TMO_EN to add the stall watchdog.
module ctrlwei_sched #(
    parameter int unsigned NUM_PEC = 48,
    parameter int unsigned ROUND_W = 8,
    parameter int unsigned TMO_W   = 10
) (
    input logic             clk,
    input logic             rst_n,
    ctrlwei_sched_if.master bus
);
    localparam int unsigned IdW = (NUM_PEC > 1) ? $clog2(NUM_PEC) : 1;
    localparam logic [IdW-1:0]     IdTop   = IdW'(NUM_PEC - 1);
    localparam logic [NUM_PEC-1:0] OneHot0 = NUM_PEC'(1);

    if (TMO_W < 2) begin : g_tmo_w_check
        $error("TMO_W must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StWaitFifo, StWaitGet, StDone} state_e;

    state_e             state_q, state_d;
    logic [NUM_PEC-1:0] mask_q, mask_d;
    logic [ROUND_W-1:0] rounds_q, rounds_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [IdW-1:0]     id_q, id_d;
    logic [NUM_PEC-1:0] rdy_q, rdy_d;
    logic               done_q, done_d;
    logic               fetch;

    logic [IdW-1:0] cfg_top, mask_top, mask_lower;
    logic           has_lower;

`ifdef CTRLWEI_STALL_TMO_EN
    localparam logic [TMO_W-1:0] TmoLast = {{(TMO_W - 1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    // Descending priority search; ascending loop so the highest qualifying index wins.
    always_comb begin
        cfg_top    = IdTop;
        mask_top   = IdTop;
        mask_lower = '0;
        has_lower  = 1'b0;
        for (int unsigned i = 0; i < NUM_PEC; i++) begin
            if (bus.CfgMask[i]) cfg_top = IdW'(i);
            if (mask_q[i]) mask_top = IdW'(i);
            if (mask_q[i] && (IdW'(i) < id_q)) begin
                mask_lower = IdW'(i);
                has_lower  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        rounds_d = rounds_q;
        round_d  = round_q;
        id_d     = id_q;
        rdy_d    = rdy_q;
        done_d   = 1'b0;
        fetch    = 1'b0;
`ifdef CTRLWEI_STALL_TMO_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        if (bus.Reset) begin
            state_d = StIdle;
            rdy_d   = '0;
            id_d    = IdTop;
            round_d = '0;
`ifdef CTRLWEI_STALL_TMO_EN
            tmo_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.Start) begin
                        mask_d   = bus.CfgMask;
                        rounds_d = bus.CfgRounds;
                        round_d  = '0;
                        id_d     = cfg_top;
                        state_d  = (bus.CfgMask == '0) ? StDone : StWaitFifo;
                    end
                end
                StWaitFifo: begin
                    if (bus.DISWEI_RdyFIFO) begin
                        fetch   = 1'b1;
                        rdy_d   = OneHot0 << id_q;
                        state_d = StWaitGet;
`ifdef CTRLWEI_STALL_TMO_EN
                        tmo_d   = '0;
`endif
                    end
                end
                StWaitGet: begin
                    if (bus.PECCTRLWEI_GetWei[id_q]) begin
                        rdy_d = '0;
                        if (has_lower) begin
                            id_d    = mask_lower;
                            state_d = StWaitFifo;
                        end else if (round_q == rounds_q) begin
                            // Last sweep finished: index and round keep their final values.
                            state_d = StDone;
                        end else begin
                            id_d    = mask_top;
                            round_d = round_q + ROUND_W'(1);
                            state_d = StWaitFifo;
                        end
                    end
`ifdef CTRLWEI_STALL_TMO_EN
                    else if (tmo_q == TmoLast) begin
                        err_d   = 1'b1;
                        rdy_d   = '0;
                        state_d = StIdle;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
`endif
                end
                StDone: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            rounds_q <= '0;
            round_q  <= '0;
            id_q     <= IdTop;
            rdy_q    <= '0;
            done_q   <= 1'b0;
`ifdef CTRLWEI_STALL_TMO_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            rounds_q <= rounds_d;
            round_q  <= round_d;
            id_q     <= id_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
`ifdef CTRLWEI_STALL_TMO_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.CTRLWEI_PlsFetch  = fetch;
    assign bus.CTRLWEIPEC_RdyWei = rdy_q;
    assign bus.CTRLWEI_Done      = done_q;
    assign bus.CTRLWEI_Busy      = (state_q != StIdle);
    assign bus.CTRLWEI_IdPec     = id_q;
    assign bus.CTRLWEI_Round     = round_q;
`ifdef CTRLWEI_STALL_TMO_EN
    assign bus.CTRLWEI_Err       = err_q;
`else
    assign bus.CTRLWEI_Err       = 1'b0;
`endif
endmodule

// File: tb/tb_ctrlwei_sched.sv
// Randomised self-checking bench for ctrlwei_sched (NUM_PEC=4); expected token order comes from
// a sweep list built directly from mask and round count.
module tb_ctrlwei_sched;
    localparam int unsigned NP = 4;
    localparam int unsigned RW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ctrlwei_sched_if #(.NUM_PEC(NP), .ROUND_W(RW)) bus ();

    ctrlwei_sched #(.NUM_PEC(NP), .ROUND_W(RW), .TMO_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Start             = 1'b0;
        bus.Reset             = 1'b0;
        bus.CfgMask           = '0;
        bus.CfgRounds         = '0;
        bus.DISWEI_RdyFIFO    = 1'b0;
        bus.PECCTRLWEI_GetWei = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.DISWEI_RdyFIFO = 1'b1;
        #12;
        checks++;
        if (bus.CTRLWEIPEC_RdyWei !== 4'b0 || bus.CTRLWEI_Done !== 1'b0 || bus.CTRLWEI_Err !== 1'b0 ||
            bus.CTRLWEI_Round !== 8'd0 || bus.CTRLWEI_IdPec !== 2'd3 || bus.CTRLWEI_Busy !== 1'b0 ||
            bus.CTRLWEI_PlsFetch !== 1'b0) begin
            failures++;
            $display("FAIL reset: rdy=%b done=%b err=%b rnd=%0d id=%0d busy=%b fetch=%b need 0,0,0,0,3,0,0",
                     bus.CTRLWEIPEC_RdyWei, bus.CTRLWEI_Done, bus.CTRLWEI_Err, bus.CTRLWEI_Round,
                     bus.CTRLWEI_IdPec, bus.CTRLWEI_Busy, bus.CTRLWEI_PlsFetch);
        end
        rst_n = 1'b1;
        bus.DISWEI_RdyFIFO = 1'b0;
        tick();
    endtask

    // Runs one job; abort_at >= 0 fires a soft Reset while holding that token instead of GetWei.
    task automatic run_job(input logic [3:0] mask, input int rounds, input int abort_at);
        int         exp_idx[$];
        int         exp_rnd[$];
        int         d;
        int         h;
        logic [3:0] oh;
        for (int r = 0; r <= rounds; r++)
            for (int i = NP - 1; i >= 0; i--)
                if (mask[i]) begin
                    exp_idx.push_back(i);
                    exp_rnd.push_back(r);
                end
        bus.CfgMask   = mask;
        bus.CfgRounds = RW'(rounds);
        bus.Start     = 1'b1;
        tick();
        bus.Start   = 1'b0;
        bus.CfgMask = 4'($urandom);
        if (mask == 4'b0) begin
            bus.DISWEI_RdyFIFO = 1'b1;
            #1;
            checks++;
            if (bus.CTRLWEI_Busy !== 1'b1 || bus.CTRLWEI_PlsFetch !== 1'b0 || bus.CTRLWEI_Done !== 1'b0) begin
                failures++;
                $display("FAIL empty_mask_done_state: busy=%b fetch=%b done=%b need 1,0,0",
                         bus.CTRLWEI_Busy, bus.CTRLWEI_PlsFetch, bus.CTRLWEI_Done);
            end
            tick();
            checks++;
            if (bus.CTRLWEI_Done !== 1'b1 || bus.CTRLWEI_Busy !== 1'b0 || bus.CTRLWEIPEC_RdyWei !== 4'b0) begin
                failures++;
                $display("FAIL empty_mask_done_pulse: done=%b busy=%b rdy=%b need 1,0,0000",
                         bus.CTRLWEI_Done, bus.CTRLWEI_Busy, bus.CTRLWEIPEC_RdyWei);
            end
            tick();
            checks++;
            if (bus.CTRLWEI_Done !== 1'b0) begin
                failures++;
                $display("FAIL empty_mask_done_width: done=%b need 0", bus.CTRLWEI_Done);
            end
            bus.DISWEI_RdyFIFO = 1'b0;
            return;
        end
        foreach (exp_idx[k]) begin
            oh = 4'b0001 << exp_idx[k];
            d  = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                bus.DISWEI_RdyFIFO = 1'b0;
                #1;
                checks++;
                if (bus.CTRLWEI_PlsFetch !== 1'b0 || bus.CTRLWEIPEC_RdyWei !== 4'b0 ||
                    bus.CTRLWEI_IdPec !== exp_idx[k] || bus.CTRLWEI_Round !== exp_rnd[k] ||
                    bus.CTRLWEI_Busy !== 1'b1) begin
                    failures++;
                    $display("FAIL wait_fifo k=%0d: fetch=%b rdy=%b id=%0d rnd=%0d busy=%b need 0,0000,%0d,%0d,1",
                             k, bus.CTRLWEI_PlsFetch, bus.CTRLWEIPEC_RdyWei, bus.CTRLWEI_IdPec,
                             bus.CTRLWEI_Round, bus.CTRLWEI_Busy, exp_idx[k], exp_rnd[k]);
                end
                tick();
            end
            bus.DISWEI_RdyFIFO = 1'b1;
            #1;
            checks++;
            if (bus.CTRLWEI_PlsFetch !== 1'b1 || bus.CTRLWEIPEC_RdyWei !== 4'b0) begin
                failures++;
                $display("FAIL fetch_pulse k=%0d: fetch=%b rdy=%b need 1,0000",
                         k, bus.CTRLWEI_PlsFetch, bus.CTRLWEIPEC_RdyWei);
            end
            tick();
            bus.DISWEI_RdyFIFO = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (bus.CTRLWEIPEC_RdyWei !== oh || bus.CTRLWEI_PlsFetch !== 1'b0 ||
                bus.CTRLWEI_IdPec !== exp_idx[k] || bus.CTRLWEI_Round !== exp_rnd[k]) begin
                failures++;
                $display("FAIL token k=%0d: rdy=%b fetch=%b id=%0d rnd=%0d need %b,0,%0d,%0d",
                         k, bus.CTRLWEIPEC_RdyWei, bus.CTRLWEI_PlsFetch, bus.CTRLWEI_IdPec,
                         bus.CTRLWEI_Round, oh, exp_idx[k], exp_rnd[k]);
            end
            h = $urandom_range(0, 3);
            for (int c = 0; c < h; c++) begin
                // Wrong-PEC strobes and stray Starts must both be ignored here.
                bus.PECCTRLWEI_GetWei = 4'($urandom) & ~oh;
                bus.Start             = 1'($urandom_range(0, 1));
                bus.CfgMask           = 4'($urandom);
                #1;
                checks++;
                if (bus.CTRLWEIPEC_RdyWei !== oh || bus.CTRLWEI_IdPec !== exp_idx[k] ||
                    bus.CTRLWEI_Round !== exp_rnd[k] || bus.CTRLWEI_Done !== 1'b0 ||
                    bus.CTRLWEI_PlsFetch !== 1'b0) begin
                    failures++;
                    $display("FAIL token_hold k=%0d: rdy=%b id=%0d rnd=%0d done=%b fetch=%b need %b,%0d,%0d,0,0",
                             k, bus.CTRLWEIPEC_RdyWei, bus.CTRLWEI_IdPec, bus.CTRLWEI_Round,
                             bus.CTRLWEI_Done, bus.CTRLWEI_PlsFetch, oh, exp_idx[k], exp_rnd[k]);
                end
                tick();
            end
            bus.Start = 1'b0;
            if (k == abort_at) begin
                bus.Reset             = 1'b1;
                bus.PECCTRLWEI_GetWei = oh;
                bus.DISWEI_RdyFIFO    = 1'b1;
                #1;
                checks++;
                if (bus.CTRLWEI_PlsFetch !== 1'b0) begin
                    failures++;
                    $display("FAIL soft_reset_fetch: fetch=%b need 0", bus.CTRLWEI_PlsFetch);
                end
                tick();
                bus.Reset             = 1'b0;
                bus.PECCTRLWEI_GetWei = '0;
                bus.DISWEI_RdyFIFO    = 1'b0;
                #1;
                checks++;
                if (bus.CTRLWEI_Busy !== 1'b0 || bus.CTRLWEIPEC_RdyWei !== 4'b0 ||
                    bus.CTRLWEI_IdPec !== 2'd3 || bus.CTRLWEI_Round !== 8'd0 ||
                    bus.CTRLWEI_Done !== 1'b0) begin
                    failures++;
                    $display("FAIL soft_reset_state: busy=%b rdy=%b id=%0d rnd=%0d done=%b need 0,0000,3,0,0",
                             bus.CTRLWEI_Busy, bus.CTRLWEIPEC_RdyWei, bus.CTRLWEI_IdPec,
                             bus.CTRLWEI_Round, bus.CTRLWEI_Done);
                end
                tick();
                checks++;
                if (bus.CTRLWEI_Done !== 1'b0 || bus.CTRLWEI_Busy !== 1'b0) begin
                    failures++;
                    $display("FAIL soft_reset_after: done=%b busy=%b need 0,0",
                             bus.CTRLWEI_Done, bus.CTRLWEI_Busy);
                end
                return;
            end
            bus.PECCTRLWEI_GetWei = oh | (4'($urandom) & ~oh);
            tick();
            bus.PECCTRLWEI_GetWei = '0;
            #1;
            checks++;
            if (bus.CTRLWEIPEC_RdyWei !== 4'b0 || bus.CTRLWEI_Done !== 1'b0 ||
                bus.CTRLWEI_Busy !== 1'b1) begin
                failures++;
                $display("FAIL token_clear k=%0d: rdy=%b done=%b busy=%b need 0000,0,1",
                         k, bus.CTRLWEIPEC_RdyWei, bus.CTRLWEI_Done, bus.CTRLWEI_Busy);
            end
        end
        bus.DISWEI_RdyFIFO = 1'b0;
        tick();
        checks++;
        if (bus.CTRLWEI_Done !== 1'b1 || bus.CTRLWEI_Busy !== 1'b0 ||
            bus.CTRLWEI_IdPec !== exp_idx[$] || bus.CTRLWEI_Round !== rounds) begin
            failures++;
            $display("FAIL job_done: done=%b busy=%b id=%0d rnd=%0d need 1,0,%0d,%0d",
                     bus.CTRLWEI_Done, bus.CTRLWEI_Busy, bus.CTRLWEI_IdPec, bus.CTRLWEI_Round,
                     exp_idx[$], rounds);
        end
        tick();
        checks++;
        if (bus.CTRLWEI_Done !== 1'b0 || bus.CTRLWEI_Busy !== 1'b0) begin
            failures++;
            $display("FAIL job_done_width: done=%b busy=%b need 0,0", bus.CTRLWEI_Done, bus.CTRLWEI_Busy);
        end
    endtask

    task automatic test_full_sweep();
        run_job(4'b1111, 0, -1);
    endtask

    task automatic test_multi_round();
        run_job(4'b1010, 2, -1);
        run_job(4'b0100, 1, -1);
    endtask

    task automatic test_empty_mask();
        run_job(4'b0000, 3, -1);
    endtask

    task automatic test_soft_reset();
        run_job(4'b1111, 2, 5);
        run_job(4'b1111, 0, -1);
    endtask

    task automatic test_reset_vs_start();
        bus.CfgMask   = 4'b1111;
        bus.CfgRounds = '0;
        bus.Start     = 1'b1;
        bus.Reset     = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.Reset = 1'b0;
        checks++;
        if (bus.CTRLWEI_Busy !== 1'b0 || bus.CTRLWEI_Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_vs_start: busy=%b done=%b need 0,0", bus.CTRLWEI_Busy, bus.CTRLWEI_Done);
        end
        tick();
        checks++;
        if (bus.CTRLWEI_Busy !== 1'b0 || bus.CTRLWEI_Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_vs_start_after: busy=%b done=%b need 0,0",
                     bus.CTRLWEI_Busy, bus.CTRLWEI_Done);
        end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 8; j++)
            run_job(4'($urandom), $urandom_range(0, 2), -1);
    endtask

`ifdef CTRLWEI_STALL_TMO_EN
    task automatic test_stall();
        bus.CfgMask        = 4'b0100;
        bus.CfgRounds      = '0;
        bus.Start          = 1'b1;
        bus.DISWEI_RdyFIFO = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        bus.DISWEI_RdyFIFO = 1'b0;
        checks++;
        if (bus.CTRLWEIPEC_RdyWei !== 4'b0100) begin
            failures++;
            $display("FAIL stall_token: rdy=%b need 0100", bus.CTRLWEIPEC_RdyWei);
        end
        for (int c = 1; c < 15; c++) begin
            tick();
            checks++;
            if (bus.CTRLWEI_Err !== 1'b0 || bus.CTRLWEIPEC_RdyWei !== 4'b0100) begin
                failures++;
                $display("FAIL stall_wait c=%0d: err=%b rdy=%b need 0,0100",
                         c, bus.CTRLWEI_Err, bus.CTRLWEIPEC_RdyWei);
            end
        end
        tick();
        checks++;
        if (bus.CTRLWEI_Err !== 1'b1 || bus.CTRLWEIPEC_RdyWei !== 4'b0 ||
            bus.CTRLWEI_Busy !== 1'b0 || bus.CTRLWEI_Done !== 1'b0) begin
            failures++;
            $display("FAIL stall_timeout: err=%b rdy=%b busy=%b done=%b need 1,0000,0,0",
                     bus.CTRLWEI_Err, bus.CTRLWEIPEC_RdyWei, bus.CTRLWEI_Busy, bus.CTRLWEI_Done);
        end
        tick();
        tick();
        checks++;
        if (bus.CTRLWEI_Err !== 1'b1 || bus.CTRLWEI_Done !== 1'b0) begin
            failures++;
            $display("FAIL stall_sticky: err=%b done=%b need 1,0", bus.CTRLWEI_Err, bus.CTRLWEI_Done);
        end
        bus.Reset = 1'b1;
        tick();
        bus.Reset = 1'b0;
        checks++;
        if (bus.CTRLWEI_Err !== 1'b0) begin
            failures++;
            $display("FAIL stall_clear: err=%b need 0", bus.CTRLWEI_Err);
        end
    endtask
`else
    task automatic test_stall();
        checks++;
        if (bus.CTRLWEI_Err !== 1'b0) begin
            failures++;
            $display("FAIL err_tied: err=%b need 0", bus.CTRLWEI_Err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_sweep();
        test_multi_round();
        test_empty_mask();
        test_soft_reset();
        test_reset_vs_start();
        test_random_jobs();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
